// File: rtl/edge_detect_pkg.sv
// Shared constants, command encodings and FSM state type for the edge-detect
// sequencer and its result clamp.
package edge_detect_pkg;

  localparam int PIX_W = 16;
  localparam int N_PIX = 9;

  localparam logic [PIX_W-1:0] CMD_IDLE = 16'h0000;
  localparam logic [PIX_W-1:0] CMD_READ = 16'h0200;

  // ST_LOAD is the single cycle after a window is accepted; the datapath bus
  // stays idle while the freshly captured bank becomes the dp_data source.
  // SETUP/STROBE are shared by all nine pixels; the pixel index counter
  // selects which one.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SETUP     = 3'd2,
    ST_STROBE    = 3'd3,
    ST_RD_SETUP  = 3'd4,
    ST_RD_STROBE = 3'd5,
    ST_OUT       = 3'd6
  } state_t;

  // One-hot load command for pixel k (1..9).
  function automatic logic [PIX_W-1:0] cmd_pix(input logic [3:0] k);
    cmd_pix = 16'h0001 << (k - 4'd1);
  endfunction

endpackage

// File: rtl/edge_result_clamp.sv
// Combinational saturation of the signed convolution result into
// [0, CLAMP_MAX]. With CLAMP_EN=0 the raw value passes through and sat stays 0.
module edge_result_clamp
  import edge_detect_pkg::*;
#(
  parameter bit          CLAMP_EN  = 1'b1,
  parameter int unsigned CLAMP_MAX = 255
) (
  input  logic [PIX_W-1:0] result,
  output logic [PIX_W-1:0] data,
  output logic             sat
);

  localparam logic [PIX_W-1:0] MAX_V = PIX_W'(CLAMP_MAX);

  // Negative results clamp to 0; positive results above MAX_V clamp to MAX_V.
  always_comb begin
    data = result;
    sat  = 1'b0;
    if (CLAMP_EN) begin
      if (result[PIX_W-1]) begin
        data = '0;
        sat  = 1'b1;
      end else if (result > MAX_V) begin
        data = MAX_V;
        sat  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_detect_sequencer.sv
// Sequences one 3x3 window at a time through the edge_detect datapath:
// captures the window, loads the nine pixels via one-hot commands, issues the
// read, clamps the result and offers it on the output stream.
//
// Handshakes: both streams use valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both 1. s_ready is 1 only in IDLE;
// once m_valid is raised it, m_data and m_sat hold until the transfer.
//
// All outputs are registered. The output registers are loaded from the
// next-state decode, so each output lines up with the state it belongs to.
module edge_detect_sequencer
  import edge_detect_pkg::*;
#(
  parameter bit          CLAMP_EN  = 1'b1,
  parameter int unsigned CLAMP_MAX = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N_PIX*PIX_W-1:0] s_window,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIX_W-1:0]       m_data,
  output logic                   m_sat,
  output logic [PIX_W-1:0]       dp_data,
  output logic [PIX_W-1:0]       dp_cmd,
  input  logic [PIX_W-1:0]       dp_result,
  output logic [PIX_W-1:0]       win_count,
  output state_t                 dbg_state
);

  state_t           state;
  state_t           next_state;
  logic [3:0]       idx;
  logic [3:0]       next_idx;
  logic [PIX_W-1:0] bank [N_PIX];
  logic [PIX_W-1:0] cmd_d;
  logic [PIX_W-1:0] data_d;
  logic [PIX_W-1:0] clamp_data;
  logic             clamp_sat;
  logic             accept;
  logic             out_fire;

  assign accept    = s_valid & s_ready;
  assign out_fire  = m_valid & m_ready;
  assign dbg_state = state;

  edge_result_clamp #(
    .CLAMP_EN  (CLAMP_EN),
    .CLAMP_MAX (CLAMP_MAX)
  ) u_clamp (
    .result (dp_result),
    .data   (clamp_data),
    .sat    (clamp_sat)
  );

  // State register and pixel index counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= 4'd0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  // Next-state logic plus the datapath bus values for the next state.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    cmd_d      = CMD_IDLE;
    data_d     = dp_data;

    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        next_state = ST_SETUP;
        next_idx   = 4'd0;
      end
      ST_SETUP: begin
        next_state = ST_STROBE;
      end
      ST_STROBE: begin
        if (idx == 4'(N_PIX - 1)) begin
          next_state = ST_RD_SETUP;
        end else begin
          next_state = ST_SETUP;
          next_idx   = idx + 4'd1;
        end
      end
      ST_RD_SETUP: begin
        next_state = ST_RD_STROBE;
      end
      ST_RD_STROBE: begin
        next_state = ST_OUT;
      end
      ST_OUT: begin
        if (out_fire) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    // dp_data is put up in SETUP and held through STROBE, so it is stable a
    // full cycle before the command bit that latches it.
    case (next_state)
      ST_SETUP: begin
        data_d = bank[next_idx];
      end
      ST_STROBE: begin
        data_d = bank[next_idx];
        cmd_d  = cmd_pix(next_idx + 4'd1);
      end
      ST_RD_STROBE: begin
        cmd_d = CMD_READ;
      end
      default: begin
        cmd_d = CMD_IDLE;
      end
    endcase
  end

  // Window register bank, loaded on the accepting edge only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_PIX; k++) bank[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < N_PIX; k++) bank[k] <= s_window[k*PIX_W +: PIX_W];
    end
  end

  // Registered stream handshakes and datapath bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      dp_cmd  <= CMD_IDLE;
      dp_data <= '0;
    end else begin
      s_ready <= (next_state == ST_IDLE);
      m_valid <= (next_state == ST_OUT);
      dp_cmd  <= cmd_d;
      dp_data <= data_d;
    end
  end

  // Result capture at the edge that ends RD_STROBE; held until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_data <= '0;
      m_sat  <= 1'b0;
    end else if (state == ST_RD_STROBE) begin
      m_data <= clamp_data;
      m_sat  <= clamp_sat;
    end
  end

  // Completed-window counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_count <= '0;
    end else if (state == ST_OUT && out_fire) begin
      win_count <= win_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_edge_detect_sequencer.sv
// Bench for edge_detect_sequencer: two instances (clamped and raw) share the
// stimulus, each drives its own behavioural edge_detect datapath model.
module tb_edge_detect_sequencer;
  import edge_detect_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         s_valid;
  logic [143:0] s_window;
  logic         m_ready;

  logic         s_ready_a, m_valid_a, m_sat_a, s_ready_b, m_valid_b, m_sat_b;
  logic [15:0]  m_data_a, dp_data_a, dp_cmd_a, dp_result_a, win_count_a;
  logic [15:0]  m_data_b, dp_data_b, dp_cmd_b, dp_result_b, win_count_b;
  state_t       dbg_state_a, dbg_state_b;

  edge_detect_sequencer #(.CLAMP_EN(1'b1), .CLAMP_MAX(255)) dut_a (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_window(s_window), .m_valid(m_valid_a), .m_ready(m_ready),
    .m_data(m_data_a), .m_sat(m_sat_a), .dp_data(dp_data_a), .dp_cmd(dp_cmd_a),
    .dp_result(dp_result_a), .win_count(win_count_a), .dbg_state(dbg_state_a)
  );

  edge_detect_sequencer #(.CLAMP_EN(1'b0), .CLAMP_MAX(255)) dut_b (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_window(s_window), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_data(m_data_b), .m_sat(m_sat_b), .dp_data(dp_data_b), .dp_cmd(dp_cmd_b),
    .dp_result(dp_result_b), .win_count(win_count_b), .dbg_state(dbg_state_b)
  );

  // ---------------- behavioural datapath models ----------------
  // Pixel k latches Data_in while Command bit k-1 is set; Data_out is
  // 8*centre - sum(neighbours) only while the read command is present.
  logic [15:0] pa [1:9];
  logic [15:0] pb [1:9];

  always @(posedge clk) begin
    for (int k = 1; k <= 9; k++) begin
      if (dp_cmd_a[k-1]) pa[k] <= dp_data_a;
      if (dp_cmd_b[k-1]) pb[k] <= dp_data_b;
    end
  end

  assign dp_result_a = dp_cmd_a[9] ? 16'((pa[5] << 3) - (pa[1] + pa[2] + pa[3] + pa[4]
                       + pa[6] + pa[7] + pa[8] + pa[9])) : 16'hDEAD;
  assign dp_result_b = dp_cmd_b[9] ? 16'((pb[5] << 3) - (pb[1] + pb[2] + pb[3] + pb[4]
                       + pb[6] + pb[7] + pb[8] + pb[9])) : 16'hDEAD;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] cmd_log [$];
  logic        trace_on = 1'b0;
  logic [15:0] prev_cmd_a = 16'h0;
  logic [15:0] prev_data_a = 16'h0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus protocol: every strobe is one-hot, preceded by an idle command, and
  // its data was already on the bus the cycle before.
  always @(negedge clk) begin
    if (!reset && dp_cmd_a != 16'h0) begin
      check("cmd_onehot", 16'($onehot(dp_cmd_a)), 16'h1);
      check("cmd_prev_idle", prev_cmd_a, 16'h0);
      if (dp_cmd_a != CMD_READ) check("data_setup", dp_data_a, prev_data_a);
    end
    if (trace_on && dp_cmd_a != prev_cmd_a) cmd_log.push_back(dp_cmd_a);
    prev_cmd_a  <= dp_cmd_a;
    prev_data_a <= dp_data_a;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] centre;
    logic [15:0] other;
    logic [15:0] exp_a;
    logic        exp_sat_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [143:0] make_window(input logic [15:0] c, input logic [15:0] o);
    logic [143:0] w;
    for (int k = 1; k <= 9; k++) w[(k-1)*16 +: 16] = (k == 5) ? c : o;
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_result(output int n);
    n = 0;
    @(negedge clk);
    while (!m_valid_a && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("m_valid_timeout", 16'(m_valid_a), 16'h1);
  endtask

  task automatic offer_window(input logic [143:0] w);
    int n;
    @(negedge clk);
    s_window = w;
    s_valid  = 1'b1;
    n = 0;
    while (!s_ready_a && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("s_ready_timeout", 16'(s_ready_a), 16'h1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic handshake(input logic [15:0] wc_exp);
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    check("m_valid_drop", 16'(m_valid_a), 16'h0);
    check("win_count_a", win_count_a, wc_exp);
    check("win_count_b", win_count_b, wc_exp);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic [15:0] wc0;
    wc0 = win_count_a;
    offer_window(make_window(v.centre, v.other));
    wait_result(n);
    check("latency", 16'(n), 16'd21);
    check("m_valid_b", 16'(m_valid_b), 16'h1);
    check("m_data_a", m_data_a, v.exp_a);
    check("m_sat_a", 16'(m_sat_a), 16'(v.exp_sat_a));
    check("m_data_b", m_data_b, v.exp_b);
    check("m_sat_b", 16'(m_sat_b), 16'h0);
    handshake(wc0 + 16'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [15:0] wc0;

    vecs[0] = '{16'd10,  16'd10, 16'd0,   1'b0, 16'd0};
    vecs[1] = '{16'd100, 16'd0,  16'd255, 1'b1, 16'h0320};
    vecs[2] = '{16'd0,   16'd5,  16'd0,   1'b1, 16'hFFD8};
    vecs[3] = '{16'd3,   16'd1,  16'd16,  1'b0, 16'd16};
    vecs[4] = '{16'd40,  16'd5,  16'd255, 1'b1, 16'h0118};
    vecs[5] = '{16'd35,  16'd4,  16'd248, 1'b0, 16'd248};

    // Test 1: reset values while asserted, then a mid-cycle deassertion.
    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_window = '0;
    #1;
    check("rst_s_ready", 16'(s_ready_a), 16'h1);
    check("rst_m_valid", 16'(m_valid_a), 16'h0);
    check("rst_dp_cmd", dp_cmd_a, 16'h0);
    check("rst_dp_data", dp_data_a, 16'h0);
    check("rst_m_data", m_data_a, 16'h0);
    check("rst_win_count", win_count_a, 16'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("deassert_s_ready", 16'(s_ready_a), 16'h1);
    check("deassert_state", 16'(dbg_state_a), 16'(ST_IDLE));

    // Test 2: command sequence for an all-10 window, then the vector table.
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(16'h0001 << k);
      exp_q.push_back(16'h0000);
    end
    exp_q.push_back(CMD_READ);
    exp_q.push_back(16'h0000);
    @(negedge clk);
    trace_on = 1'b1;
    run_vec(vecs[0]);
    trace_on = 1'b0;
    check("trace_len", 16'(cmd_log.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
      check("trace_cmd", cmd_log[i], exp_q[i]);
    for (int i = 1; i < 6; i++) run_vec(vecs[i]);

    // Test 5: backpressure with s_valid held during the busy window.
    wc0 = win_count_a;
    offer_window(make_window(16'd100, 16'd0));
    s_window = make_window(16'd0, 16'd5);
    s_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_s_ready", 16'(s_ready_a), 16'h0);
    end
    wait_result(n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_m_valid", 16'(m_valid_a), 16'h1);
      check("bp_m_data_a", m_data_a, 16'd255);
      check("bp_m_data_b", m_data_b, 16'h0320);
      check("bp_dp_cmd", dp_cmd_a, 16'h0);
      check("bp_s_ready", 16'(s_ready_a), 16'h0);
    end
    check("bp_win_count", win_count_a, wc0);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_s_ready", 16'(s_ready_a), 16'h1);
    check("bp_win_count_inc", win_count_a, wc0 + 16'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    wait_result(n);
    check("bp2_latency", 16'(n), 16'd21);
    check("bp2_m_data_a", m_data_a, 16'd0);
    check("bp2_m_sat_a", 16'(m_sat_a), 16'h1);
    check("bp2_m_data_b", m_data_b, 16'hFFD8);
    handshake(wc0 + 16'd2);

    // Test 6: asynchronous reset during STROBE_5, then a clean window.
    offer_window(make_window(16'd100, 16'd0));
    n = 0;
    while (dp_cmd_a != 16'h0010 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_strobe5", dp_cmd_a, 16'h0010);
    #2 reset = 1'b1;
    #1;
    check("arst_dp_cmd_a", dp_cmd_a, 16'h0);
    check("arst_dp_cmd_b", dp_cmd_b, 16'h0);
    check("arst_s_ready", 16'(s_ready_a), 16'h1);
    check("arst_m_valid", 16'(m_valid_a), 16'h0);
    check("arst_win_count", win_count_a, 16'h0);
    check("arst_state", 16'(dbg_state_a), 16'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    run_vec(vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
